// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock divider, h/v counters, address stage and colour-return pipeline.
// Optional internal colour-bar source is built only when VGA_TEST_PATTERN_EN is defined.

package vga_timing_gen_pkg;

  // Per-pixel flags that travel alongside the pixel address while the colour lookup is in flight
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fr;
`ifdef VGA_TEST_PATTERN_EN
    logic        tp;
    logic [11:0] bar;
`endif
  } pix_tag_t;

endpackage

module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned PIX_DIV    = 4,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 29,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter bit          H_POL      = 1'b0,
  parameter bit          V_POL      = 1'b0,
  parameter int unsigned H_W        = 10,
  parameter int unsigned V_W        = 10,
  parameter int unsigned COLOUR_LAT = 1
) (
  input  logic           CLK,
  input  logic           RESETN,
  input  logic [11:0]    COLOUR_IN,
  input  logic           TPAT_SEL,
  output logic [H_W-1:0] ADDRH,
  output logic [V_W-1:0] ADDRY,
  output logic           PIX_EN,
  output logic [11:0]    COLOUR_OUT,
  output logic           HS,
  output logic           VS,
  output logic           DE,
  output logic           FRAME_START
);

  localparam int unsigned DIV_W       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned H_TOT       = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOT       = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_ACT_START = H_SYNC + H_BP;
  localparam int unsigned H_ACT_LAST  = H_ACT_START + H_ACTIVE - 1;
  localparam int unsigned V_ACT_START = V_SYNC + V_BP;
  localparam int unsigned V_ACT_LAST  = V_ACT_START + V_ACTIVE - 1;

  // Configuration sanity checks at elaboration
  if (H_TOT > (2 ** H_W)) begin : g_h_cfg_err
    $error("vga_timing_gen: H_TOT=%0d does not fit in H_W=%0d bits", H_TOT, H_W);
  end
  if (V_TOT > (2 ** V_W)) begin : g_v_cfg_err
    $error("vga_timing_gen: V_TOT=%0d does not fit in V_W=%0d bits", V_TOT, V_W);
  end
  if ((PIX_DIV < 1) || (PIX_DIV > 16)) begin : g_div_cfg_err
    $error("vga_timing_gen: PIX_DIV=%0d outside 1..16", PIX_DIV);
  end
  if ((COLOUR_LAT < 1) || (COLOUR_LAT > 4)) begin : g_lat_cfg_err
    $error("vga_timing_gen: COLOUR_LAT=%0d outside 1..4", COLOUR_LAT);
  end

  logic [DIV_W-1:0] div_q;
  logic             tick_c;
  logic [H_W-1:0]   h_q;
  logic [V_W-1:0]   v_q;
  logic             h_wrap_c;
  logic             v_wrap_c;
  logic             h_act_c;
  logic             v_act_c;
  logic             frame_a_c;
  logic [H_W-1:0]   addr_h_c;
  logic [V_W-1:0]   addr_y_c;
  pix_tag_t         tag_a_c;
  pix_tag_t         tag_o_c;
  logic [11:0]      colour_c;

  pix_tag_t [COLOUR_LAT-1:0] pipe_q;
  pix_tag_t [COLOUR_LAT-1:0] pipe_nxt_c;

  // Raster decode of the current (pre-edge) counter position
  always_comb begin
    tick_c    = (div_q == DIV_W'(PIX_DIV - 1));
    h_wrap_c  = (h_q == H_W'(H_TOT - 1));
    v_wrap_c  = (v_q == V_W'(V_TOT - 1));
    h_act_c   = (h_q >= H_W'(H_ACT_START)) && (h_q <= H_W'(H_ACT_LAST));
    v_act_c   = (v_q >= V_W'(V_ACT_START)) && (v_q <= V_W'(V_ACT_LAST));
    frame_a_c = (h_q == '0) && (v_q == '0);
    addr_h_c  = h_act_c ? (h_q - H_W'(H_ACT_START)) : '0;
    addr_y_c  = v_act_c ? (v_q - V_W'(V_ACT_START)) : '0;
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  logic           tpat_q;
  logic           tpat_c;
  logic [H_W-1:0] bar_div_c;
  logic [2:0]     bar_idx_c;
  logic [11:0]    bar_col_c;

  // Bar colour for the column being issued; selection is latched once per frame
  always_comb begin
    tpat_c    = frame_a_c ? TPAT_SEL : tpat_q;
    bar_div_c = addr_h_c / H_W'(BAR_W);
    bar_idx_c = (bar_div_c > H_W'(7)) ? 3'd7 : bar_div_c[2:0];
    bar_col_c = 12'h000;
    case (bar_idx_c)
      3'd0:    bar_col_c = 12'hFFF;
      3'd1:    bar_col_c = 12'hFF0;
      3'd2:    bar_col_c = 12'h0FF;
      3'd3:    bar_col_c = 12'h0F0;
      3'd4:    bar_col_c = 12'hF0F;
      3'd5:    bar_col_c = 12'hF00;
      3'd6:    bar_col_c = 12'h00F;
      default: bar_col_c = 12'h000;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tpat_q <= 1'b0;
    end else if (tick_c) begin
      tpat_q <= tpat_c;
    end
  end
`else
  logic unused_tpat_sel;
  assign unused_tpat_sel = TPAT_SEL;
`endif

  // Flags for the pixel entering the lookup pipeline
  always_comb begin
    tag_a_c    = '0;
    tag_a_c.de = h_act_c & v_act_c;
    tag_a_c.hs = (h_q < H_W'(H_SYNC));
    tag_a_c.vs = (v_q < V_W'(V_SYNC));
    tag_a_c.fr = frame_a_c;
`ifdef VGA_TEST_PATTERN_EN
    tag_a_c.tp  = tpat_c;
    tag_a_c.bar = bar_col_c;
`endif
  end

  if (COLOUR_LAT > 1) begin : g_pipe_deep
    assign pipe_nxt_c = {pipe_q[COLOUR_LAT-2:0], tag_a_c};
  end else begin : g_pipe_flat
    assign pipe_nxt_c = tag_a_c;
  end

  // Output-stage selection: colour only inside the visible window
  always_comb begin
    tag_o_c  = pipe_q[COLOUR_LAT-1];
    colour_c = 12'h000;
    if (tag_o_c.de) begin
`ifdef VGA_TEST_PATTERN_EN
      colour_c = tag_o_c.tp ? tag_o_c.bar : COLOUR_IN;
`else
      colour_c = COLOUR_IN;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      div_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      pipe_q      <= '0;
      ADDRH       <= '0;
      ADDRY       <= '0;
      PIX_EN      <= 1'b0;
      COLOUR_OUT  <= 12'h000;
      HS          <= ~H_POL;
      VS          <= ~V_POL;
      DE          <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      PIX_EN      <= tick_c;
      FRAME_START <= 1'b0;
      div_q       <= tick_c ? '0 : div_q + DIV_W'(1);
      if (tick_c) begin
        h_q <= h_wrap_c ? '0 : h_q + H_W'(1);
        if (h_wrap_c) begin
          v_q <= v_wrap_c ? '0 : v_q + V_W'(1);
        end
        ADDRH       <= addr_h_c;
        ADDRY       <= addr_y_c;
        pipe_q      <= pipe_nxt_c;
        HS          <= tag_o_c.hs ? H_POL : ~H_POL;
        VS          <= tag_o_c.vs ? V_POL : ~V_POL;
        DE          <= tag_o_c.de;
        COLOUR_OUT  <= colour_c;
        FRAME_START <= tag_o_c.fr;
      end
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator with an integrated pixel-clock divider and a colour-return pipeline. It issues pixel addresses to the frame/sprite logic and accepts the returned colour a fixed number of pixel ticks later. HS, VS, DE and COLOUR_OUT are delayed to match, so sync and colour leave the block aligned. It sits between the 100 MHz system clock domain logic and the VGA connector, with configurable resolution, polarity and lookup latency.

Parameters:
PIX_DIV, 4, CLK cycles per pixel tick (1..16)
H_SYNC, 96, horizontal sync width in pixels
H_BP, 48, horizontal back porch in pixels
H_ACTIVE, 640, horizontal visible pixels
H_FP, 16, horizontal front porch in pixels
V_SYNC, 2, vertical sync width in lines
V_BP, 29, vertical back porch in lines
V_ACTIVE, 480, vertical visible lines
V_FP, 10, vertical front porch in lines
H_POL, 0, HS active level (0 = active low)
V_POL, 0, VS active level (0 = active low)
H_W, 10, width of horizontal counter and ADDRH
V_W, 10, width of vertical counter and ADDRY
COLOUR_LAT, 1, pixel ticks from address issue to COLOUR_IN sample (1..4)

Ports:
CLK  in  1  system clock
RESETN  in  1  asynchronous active-low reset
COLOUR_IN  in  12  {R,G,B} 4:4:4 colour for the address issued COLOUR_LAT ticks earlier
TPAT_SEL  in  1  test-pattern select (see Optional Feature)
ADDRH  out  H_W  visible column address, 0..H_ACTIVE-1
ADDRY  out  V_W  visible row address, 0..V_ACTIVE-1
PIX_EN  out  1  one-CLK pixel tick strobe
COLOUR_OUT  out  12  pixel colour to DAC
HS  out  1  horizontal sync
VS  out  1  vertical sync
DE  out  1  display enable, aligned with COLOUR_OUT
FRAME_START  out  1  one-CLK pulse at the output-stage tick of raster position (0,0)

Behaviour:
- Reset (RESETN low, asynchronous): divider, counters and pipeline = 0; HS = ~H_POL; VS = ~V_POL; DE, COLOUR_OUT, ADDRH, ADDRY, PIX_EN and FRAME_START = 0.
- Divider: counts 0..PIX_DIV-1. The tick fires when the count = PIX_DIV-1. PIX_EN is high for that one CLK. PIX_DIV=1 gives a tick on every CLK. After reset release, the first tick occurs on the PIX_DIV-th rising edge.
- Counters advance on ticks only.
  - h counts 0..H_TOT-1, where H_TOT = H_SYNC+H_BP+H_ACTIVE+H_FP.
  - At h wrap, v increments over 0..V_TOT-1 and wraps to 0.
- Region order per axis: sync, back porch, active, front porch.
  - Sync when h < H_SYNC.
  - Active when H_SYNC+H_BP <= h < H_SYNC+H_BP+H_ACTIVE. Vertical uses the same rule.
- Address stage (registered on tick n from pre-edge counts):
  - ADDRH = h-(H_SYNC+H_BP) when horizontally active, else 0.
  - ADDRY = v-(V_SYNC+V_BP) when vertically active, else 0.
  - Internal de_a = both axes active. Internal hs_a/vs_a are raw sync flags.
- Pipeline: de_a, hs_a, vs_a and frame flag pass through a COLOUR_LAT-deep shift register clocked on ticks. On tick n+COLOUR_LAT:
  - DE, HS and VS update, with polarity applied.
  - COLOUR_OUT = COLOUR_IN if delayed DE = 1, else 12'h000.
- All outputs change only on tick edges and hold between ticks, except PIX_EN and FRAME_START. FRAME_START is high for the tick CLK only.
- Counter widths: H_TOT must be <= 2^H_W and V_TOT must be <= 2^V_W. Exceeding these is a configuration error, flagged by a simulation-only $error.
- Mid-frame reset: all outputs return to reset values immediately. After release, the raster restarts at (0,0), and FRAME_START fires COLOUR_LAT ticks after the first tick.
- Default timings: 800 ticks per line, 521 lines per frame, 25 MHz pixel rate from 100 MHz CLK.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- When defined, TPAT_SEL=1 substitutes an internal colour-bar source for COLOUR_IN at the sample point. The bar source is generated at the address stage and delayed through the same pipeline.
- Eight bars, each H_ACTIVE/8 pixels wide (integer division; the bar index saturates at 7): FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
- TPAT_SEL is sampled at the start of each frame only.
- When undefined, TPAT_SEL is ignored and no bar logic is built.

Test Plan:
- Reset check: RESETN low 10 CLK with defaults -> HS=1, VS=1, DE=0, COLOUR_OUT=000, ADDRH=0, ADDRY=0, PIX_EN=0.
- Line and frame timing, defaults:
  - HS low 384 CLK per 3200-CLK line.
  - VS low 2 lines per 521-line frame.
  - DE high 640 ticks per active line and 480 lines per frame.
  - FRAME_START once per 1 667 200 CLK.
- Addressing: ADDRH sweeps 0..639 and ADDRY sweeps 0..479 in the active region, both 0 in blanking. With COLOUR_IN=F00 held -> COLOUR_OUT=F00 exactly while DE=1, else 000.
- Latency alignment: COLOUR_LAT=3, bench memory model returns {ADDRY[3:0],ADDRH[7:0]} after 3 ticks -> every DE=1 tick shows COLOUR_OUT equal to the address of that pixel, and no pixel is shifted.
- Mid-frame reset: assert RESETN low at line 200, column 300 -> outputs go to reset values within the same CLK. After release, the first FRAME_START occurs COLOUR_LAT ticks after the first tick.
- Test pattern, macro defined, TPAT_SEL=1 -> ADDRH 0..79 gives FFF, 80..159 gives FF0, ..., 560..639 gives 000. Macro undefined -> output follows COLOUR_IN.
